// File: rtl/draw_source_arbiter_pkg.sv
// draw_source_arbiter_pkg: draw geometry, source IDs and arbiter state type (DRAW_ARB_CLEAR_EN adds the CLEAR state usage)
package draw_source_arbiter_pkg;
   localparam int DRAW_WIDTH = 40;
   localparam int DRAW_HEIGHT = 30;
   localparam int COLOR_DEPTH = 9;
   localparam int SOURCE_SEL_ADDRW = 3;
   localparam int DRAW_WIDTH_ADDRW = $clog2(DRAW_WIDTH);
   localparam int DRAW_HEIGHT_ADDRW = $clog2(DRAW_HEIGHT);
   localparam int FB_ADDRW = $clog2(DRAW_WIDTH * DRAW_HEIGHT);
   localparam logic [SOURCE_SEL_ADDRW-1:0] IDLE_ID = '1;
   typedef enum logic [2:0] {IDLE, CLEAR, GRANT, STREAM, NEXT, SWAP} arb_state_t;
endpackage

// File: rtl/fb_pixel_stage.sv
// fb_pixel_stage: qualifies a pixel, maps it to a back-buffer address and registers the write (DRAW_ARB_CLEAR_EN adds the clear path)
module fb_pixel_stage
   import draw_source_arbiter_pkg::*;
`ifdef DRAW_ARB_CLEAR_EN
#(
   parameter logic [COLOR_DEPTH-1:0] BG_COLOR = '0
)
`endif
(
   input  logic                         clk,
   input  logic                         resetN,
   input  logic                         accept,
   input  logic [COLOR_DEPTH-1:0]       color,
   input  logic                         transparent,
   input  logic [DRAW_WIDTH_ADDRW-1:0]  x,
   input  logic [DRAW_HEIGHT_ADDRW-1:0] y,
`ifdef DRAW_ARB_CLEAR_EN
   input  logic                         clear_we,
   input  logic [FB_ADDRW-1:0]          clear_addr,
`endif
   output logic                         fb_we,
   output logic [FB_ADDRW-1:0]          fb_addr,
   output logic [COLOR_DEPTH-1:0]       fb_wdata
);
   logic                pix_ok;
   logic [FB_ADDRW-1:0] pix_addr;
   // a pixel is written only if opaque and inside the drawable area
   always_comb begin
      pix_ok = accept && !transparent && ({1'b0, x} < (DRAW_WIDTH_ADDRW+1)'(DRAW_WIDTH))
               && ({1'b0, y} < (DRAW_HEIGHT_ADDRW+1)'(DRAW_HEIGHT));
      pix_addr = FB_ADDRW'(y) * FB_ADDRW'(DRAW_WIDTH) + FB_ADDRW'(x);
   end
   // one-cycle registered write port into the framebuffer RAM
   always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
         fb_we <= 1'b0;
         fb_addr <= '0;
         fb_wdata <= '0;
      end
`ifdef DRAW_ARB_CLEAR_EN
      else if (clear_we) begin
         fb_we <= 1'b1;
         fb_addr <= clear_addr;
         fb_wdata <= BG_COLOR;
      end
`endif
      else begin
         fb_we <= pix_ok;
         if (pix_ok) begin
            fb_addr <= pix_addr;
            fb_wdata <= color;
         end
      end
endmodule

// File: rtl/draw_source_arbiter.sv
// draw_source_arbiter: per-frame round of source grants streaming into the back buffer, then buffer swap (DRAW_ARB_CLEAR_EN clears the back buffer first)
module draw_source_arbiter
   import draw_source_arbiter_pkg::*;
#(
   parameter int NUM_SOURCES = 4,
   parameter int GRANT_TIMEOUT = 1024,
   parameter int MAX_STREAM = 4096
`ifdef DRAW_ARB_CLEAR_EN
   , parameter logic [COLOR_DEPTH-1:0] BG_COLOR = 9'h000
`endif
)(
   input  logic                         clk,
   input  logic                         resetN,
   input  logic                         frame,
   output logic [SOURCE_SEL_ADDRW-1:0]  write_source_sel,
   output logic                         write_awaited,
   input  logic                         write_active,
   input  logic [COLOR_DEPTH-1:0]       write_color_data,
   input  logic                         write_transparent,
   input  logic [DRAW_WIDTH_ADDRW-1:0]  write_x_addr,
   input  logic [DRAW_HEIGHT_ADDRW-1:0] write_y_addr,
   output logic                         fb_we,
   output logic [FB_ADDRW-1:0]          fb_addr,
   output logic [COLOR_DEPTH-1:0]       fb_wdata,
   output logic                         fb_back_sel,
   output logic                         frame_overrun,
   output logic                         source_timeout
);
   localparam int TW = $clog2((GRANT_TIMEOUT > MAX_STREAM ? GRANT_TIMEOUT : MAX_STREAM) + 1);
   arb_state_t                  state, state_n;
   logic [SOURCE_SEL_ADDRW-1:0] src, src_n;
   logic [TW-1:0]               timer, timer_n;
   logic                        accept, timeout, last_src;
`ifdef DRAW_ARB_CLEAR_EN
   logic [FB_ADDRW-1:0]         clr_cnt, clr_cnt_n;
`endif
   // next-state logic; the GRANT->STREAM cycle already carries the first pixel, so timer starts at 1
   always_comb begin
      state_n = state;
      src_n = src;
      timer_n = timer;
      accept = 1'b0;
      timeout = 1'b0;
      last_src = src == SOURCE_SEL_ADDRW'(NUM_SOURCES - 1);
`ifdef DRAW_ARB_CLEAR_EN
      clr_cnt_n = clr_cnt;
`endif
      case (state)
         IDLE:
            if (frame) begin
`ifdef DRAW_ARB_CLEAR_EN
               state_n = CLEAR;
               clr_cnt_n = '0;
`else
               state_n = GRANT;
`endif
               src_n = '0;
               timer_n = '0;
            end
`ifdef DRAW_ARB_CLEAR_EN
         CLEAR: begin
            clr_cnt_n = clr_cnt + 1'b1;
            if (clr_cnt == FB_ADDRW'(DRAW_WIDTH * DRAW_HEIGHT - 1)) state_n = GRANT;
         end
`endif
         GRANT:
            if (write_active) begin
               state_n = STREAM;
               accept = 1'b1;
               timer_n = TW'(1);
            end else if (timer == TW'(GRANT_TIMEOUT - 1)) begin
               timeout = 1'b1;
               state_n = NEXT;
            end else timer_n = timer + 1'b1;
         STREAM:
            if (!write_active) state_n = NEXT;
            else if (timer == TW'(MAX_STREAM)) begin
               timeout = 1'b1;
               state_n = NEXT;
            end else begin
               accept = 1'b1;
               timer_n = timer + 1'b1;
            end
         NEXT: begin
            timer_n = '0;
            state_n = last_src ? SWAP : GRANT;
            src_n = last_src ? src : src + 1'b1;
         end
         SWAP: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   // grant outputs follow the state directly so reset blanks them immediately
   always_comb begin
      write_source_sel = (state == GRANT || state == STREAM) ? src : IDLE_ID;
      write_awaited = state == GRANT;
   end
   // state, counters, buffer select and status pulses
   always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
         state <= IDLE;
         src <= '0;
         timer <= '0;
         fb_back_sel <= 1'b0;
         frame_overrun <= 1'b0;
         source_timeout <= 1'b0;
`ifdef DRAW_ARB_CLEAR_EN
         clr_cnt <= '0;
`endif
      end else begin
         state <= state_n;
         src <= src_n;
         timer <= timer_n;
         fb_back_sel <= fb_back_sel ^ (state == SWAP);
         frame_overrun <= frame && state != IDLE;
         source_timeout <= timeout;
`ifdef DRAW_ARB_CLEAR_EN
         clr_cnt <= clr_cnt_n;
`endif
      end
   fb_pixel_stage
`ifdef DRAW_ARB_CLEAR_EN
      #(.BG_COLOR(BG_COLOR))
`endif
      u_pixel (
         .clk(clk),
         .resetN(resetN),
         .accept(accept),
         .color(write_color_data),
         .transparent(write_transparent),
         .x(write_x_addr),
         .y(write_y_addr),
`ifdef DRAW_ARB_CLEAR_EN
         .clear_we(state == CLEAR),
         .clear_addr(clr_cnt),
`endif
         .fb_we(fb_we),
         .fb_addr(fb_addr),
         .fb_wdata(fb_wdata)
      );
endmodule

// File: tb/tb_draw_source_arbiter.sv
// tb_draw_source_arbiter: randomized source streams checked against a pass-level model of the arbiter
module tb_draw_source_arbiter;
   import draw_source_arbiter_pkg::*;
   localparam int NS = 3;
   localparam int GT = 1024;
   localparam int MS = 4096;
   typedef struct { int x; int y; int c; bit t; } pix_t;
   typedef struct { int a; int c; } wr_t;
   logic                         clk = 1'b0;
   logic                         resetN = 1'b0;
   logic                         frame = 1'b0;
   logic                         write_active = 1'b0;
   logic [COLOR_DEPTH-1:0]       write_color_data = '0;
   logic                         write_transparent = 1'b0;
   logic [DRAW_WIDTH_ADDRW-1:0]  write_x_addr = '0;
   logic [DRAW_HEIGHT_ADDRW-1:0] write_y_addr = '0;
   logic [SOURCE_SEL_ADDRW-1:0]  write_source_sel;
   logic                         write_awaited;
   logic                         fb_we;
   logic [FB_ADDRW-1:0]          fb_addr;
   logic [COLOR_DEPTH-1:0]       fb_wdata;
   logic                         fb_back_sel;
   logic                         frame_overrun;
   logic                         source_timeout;
   int    n_checks = 0;
   int    n_fail = 0;
   int    cyc = 0;
   string tname = "";
   pix_t  pq[$];
   wr_t   exp_q[$];
   int    exp_cyc[$];
   int    base[NS], cnt[NS], idx[NS];
   bit    busy[NS], done[NS];

   draw_source_arbiter #(.NUM_SOURCES(NS), .GRANT_TIMEOUT(GT), .MAX_STREAM(MS)) dut (
      .clk(clk), .resetN(resetN), .frame(frame),
      .write_source_sel(write_source_sel), .write_awaited(write_awaited),
      .write_active(write_active), .write_color_data(write_color_data),
      .write_transparent(write_transparent), .write_x_addr(write_x_addr),
      .write_y_addr(write_y_addr), .fb_we(fb_we), .fb_addr(fb_addr),
      .fb_wdata(fb_wdata), .fb_back_sel(fb_back_sel),
      .frame_overrun(frame_overrun), .source_timeout(source_timeout)
   );

   always #5 clk = ~clk;

   task automatic new_setup();
      pq.delete();
      for (int j = 0; j < NS; j++) begin
         base[j] = 0;
         cnt[j] = 0;
      end
   endtask

   task automatic add_pix(input int j, input int x, input int y, input int c, input bit t);
      pix_t p;
      if (cnt[j] == 0) base[j] = pq.size();
      p.x = x;
      p.y = y;
      p.c = c;
      p.t = t;
      pq.push_back(p);
      cnt[j]++;
   endtask

   task automatic add_src(input int j, input int n, input bit valid_only);
      for (int k = 0; k < n; k++)
         if (valid_only) add_pix(j, $urandom_range(0, DRAW_WIDTH - 1), $urandom_range(0, DRAW_HEIGHT - 1),
                                 $urandom_range(0, 511), 1'b0);
         else add_pix(j, $urandom_range(0, DRAW_WIDTH + 3), $urandom_range(0, DRAW_HEIGHT + 1),
                      $urandom_range(0, 511), $urandom_range(0, 7) == 0);
   endtask

   // source models: start on own grant, stream cnt pixels one per cycle; bus muxed by write_source_sel
   task automatic step_bus();
      int   s;
      pix_t p;
      for (int j = 0; j < NS; j++)
         if (busy[j]) begin
            idx[j]++;
            if (idx[j] >= cnt[j]) begin
               busy[j] = 1'b0;
               done[j] = 1'b1;
            end
         end else if (!done[j] && cnt[j] > 0 && write_awaited === 1'b1 && int'(write_source_sel) == j) begin
            busy[j] = 1'b1;
            idx[j] = 0;
         end
      s = int'(write_source_sel);
      write_active = 1'b0;
      write_x_addr = '0;
      write_y_addr = '0;
      write_color_data = '0;
      write_transparent = 1'b0;
      if (s < NS) if (busy[s]) begin
         p = pq[base[s] + idx[s]];
         write_active = 1'b1;
         write_x_addr = DRAW_WIDTH_ADDRW'(p.x);
         write_y_addr = DRAW_HEIGHT_ADDRW'(p.y);
         write_color_data = COLOR_DEPTH'(p.c);
         write_transparent = p.t;
         if (!p.t && p.x < DRAW_WIDTH && p.y < DRAW_HEIGHT && idx[s] < MS) exp_cyc.push_back(cyc + 1);
      end
   endtask

   task automatic run_pass(input int ovr_at, input bit swap_hit);
      int   wi, tmo, ovr, tog, grant_cyc, last_sel, nxt_k, end_k, exp_tmo, m;
      int   ord[$];
      bit   ord_ok;
      logic b0;
      wr_t  w;
      wi = 0; tmo = 0; ovr = 0; tog = 0; grant_cyc = 0; last_sel = -1; nxt_k = 0; end_k = -1; exp_tmo = 0;
      exp_q.delete();
      exp_cyc.delete();
      for (int j = 0; j < NS; j++) begin
         busy[j] = 1'b0;
         done[j] = 1'b0;
         idx[j] = 0;
         m = cnt[j] < MS ? cnt[j] : MS;
         for (int k = 0; k < m; k++)
            if (!pq[base[j] + k].t && pq[base[j] + k].x < DRAW_WIDTH && pq[base[j] + k].y < DRAW_HEIGHT) begin
               w.a = pq[base[j] + k].y * DRAW_WIDTH + pq[base[j] + k].x;
               w.c = pq[base[j] + k].c;
               exp_q.push_back(w);
            end
         if (cnt[j] == 0 || cnt[j] > MS) exp_tmo++;
      end
      b0 = fb_back_sel;
      @(negedge clk);
      frame = 1'b1;
      for (int k = 1; k < 3 * (GT + MS + 20) + 100 && (end_k < 0 || k < end_k + 6); k++) begin
         @(negedge clk);
         cyc++;
         if (fb_we === 1'b1) begin
            n_checks++;
            if (wi >= exp_q.size()) begin
               n_fail++;
               $display("FAIL %s extra_write: got addr=%0d data=%h, required no write", tname, fb_addr, fb_wdata);
            end else if (fb_addr !== FB_ADDRW'(exp_q[wi].a) || fb_wdata !== COLOR_DEPTH'(exp_q[wi].c) || cyc != exp_cyc[wi]) begin
               n_fail++;
               $display("FAIL %s write[%0d]: got addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                        tname, wi, fb_addr, fb_wdata, cyc, exp_q[wi].a, exp_q[wi].c, exp_cyc[wi]);
            end
            wi++;
         end
         if (source_timeout === 1'b1) begin
            tmo++;
            if (last_sel >= 0) if (cnt[last_sel] == 0) begin
               n_checks++;
               if (cyc - grant_cyc !== GT) begin
                  n_fail++;
                  $display("FAIL %s timeout_delay: got %0d cycles after grant, required %0d", tname, cyc - grant_cyc, GT);
               end
            end
         end
         if (frame_overrun === 1'b1) ovr++;
         if (write_source_sel !== IDLE_ID && int'(write_source_sel) != last_sel) begin
            ord.push_back(int'(write_source_sel));
            last_sel = int'(write_source_sel);
            grant_cyc = cyc;
         end
         if (write_source_sel === IDLE_ID && last_sel == NS - 1 && nxt_k == 0) nxt_k = k;
         if (fb_back_sel !== b0) begin
            tog++;
            b0 = fb_back_sel;
            if (end_k < 0) end_k = k;
         end
         frame = (k == ovr_at) || (swap_hit && nxt_k != 0 && k == nxt_k + 1);
         step_bus();
      end
      frame = 1'b0;
      n_checks++;
      if (wi !== exp_q.size()) begin
         n_fail++;
         $display("FAIL %s write_count: got %0d, required %0d", tname, wi, exp_q.size());
      end
      n_checks++;
      if (tmo !== exp_tmo) begin
         n_fail++;
         $display("FAIL %s timeout_count: got %0d, required %0d", tname, tmo, exp_tmo);
      end
      n_checks++;
      if (ovr !== int'(ovr_at > 0) + int'(swap_hit)) begin
         n_fail++;
         $display("FAIL %s overrun_count: got %0d, required %0d", tname, ovr, int'(ovr_at > 0) + int'(swap_hit));
      end
      n_checks++;
      if (tog !== 1) begin
         n_fail++;
         $display("FAIL %s swap_count: got %0d, required 1", tname, tog);
      end
      ord_ok = ord.size() == NS;
      for (int i = 0; i < ord.size() && i < NS; i++) ord_ok &= ord[i] == i;
      n_checks++;
      if (!ord_ok) begin
         n_fail++;
         $display("FAIL %s grant_order: got %0d grants (first %0d), required 0..%0d in order", tname, ord.size(),
                  ord.size() > 0 ? ord[0] : -1, NS - 1);
      end
   endtask

   task automatic test_reset();
      tname = "reset";
      #12;
      n_checks++;
      if (write_source_sel !== IDLE_ID || write_awaited !== 1'b0 || fb_we !== 1'b0 || fb_addr !== '0 ||
          fb_wdata !== '0 || fb_back_sel !== 1'b0 || frame_overrun !== 1'b0 || source_timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_values: got sel=%0d aw=%b we=%b addr=%0d data=%h back=%b ovr=%b tmo=%b, required sel=%0d and zeros",
                  write_source_sel, write_awaited, fb_we, fb_addr, fb_wdata, fb_back_sel, frame_overrun, source_timeout, IDLE_ID);
      end
      @(negedge clk);
      resetN = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (write_source_sel !== IDLE_ID || fb_we !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_hold: got sel=%0d we=%b, required sel=%0d we=0", write_source_sel, fb_we, IDLE_ID);
      end
   endtask

   task automatic test_basic_pass();
      tname = "basic";
      new_setup();
      add_src(0, 50, 1'b0);
      add_src(2, 5, 1'b0);
      run_pass(0, 1'b0);
   endtask

   task automatic test_pixel_boundaries();
      tname = "pixel";
      new_setup();
      add_pix(0, 10, 2, 'h1FF, 1'b0);
      add_pix(2, 5, 5, 'h003, 1'b1);
      add_pix(2, DRAW_WIDTH, 3, 'h004, 1'b0);
      add_pix(2, 3, DRAW_HEIGHT, 'h005, 1'b0);
      add_pix(2, DRAW_WIDTH - 1, DRAW_HEIGHT - 1, 'h0AB, 1'b0);
      add_pix(2, 0, 0, 'h100, 1'b0);
      run_pass(0, 1'b0);
   endtask

   task automatic test_overrun();
      tname = "overrun";
      new_setup();
      add_src(0, 50, 1'b0);
      add_src(2, 5, 1'b0);
      run_pass(20, 1'b0);
   endtask

   task automatic test_swap_frame();
      tname = "swap_frame";
      new_setup();
      add_src(0, 7, 1'b0);
      add_src(1, 3, 1'b0);
      add_src(2, 4, 1'b0);
      run_pass(0, 1'b1);
   endtask

   task automatic test_max_stream();
      tname = "max_stream";
      new_setup();
      add_src(0, MS + 10, 1'b1);
      add_src(2, 5, 1'b1);
      run_pass(0, 1'b0);
   endtask

   task automatic test_random();
      for (int r = 0; r < 3; r++) begin
         tname = $sformatf("random%0d", r);
         new_setup();
         for (int j = 0; j < NS; j++) add_src(j, $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 60), 1'b0);
         run_pass(r == 1 ? $urandom_range(2, 30) : 0, 1'b0);
      end
   endtask

   task automatic test_reset_mid();
      tname = "reset_mid";
      new_setup();
      add_src(0, 50, 1'b1);
      add_src(2, 5, 1'b1);
      for (int j = 0; j < NS; j++) begin
         busy[j] = 1'b0;
         done[j] = 1'b0;
      end
      @(negedge clk);
      frame = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         cyc++;
         frame = 1'b0;
         step_bus();
      end
      #2 resetN = 1'b0;
      #1;
      n_checks++;
      if (write_source_sel !== IDLE_ID || fb_we !== 1'b0 || write_awaited !== 1'b0 || fb_back_sel !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid: got sel=%0d we=%b aw=%b back=%b, required sel=%0d we=0 aw=0 back=0",
                  write_source_sel, fb_we, write_awaited, fb_back_sel, IDLE_ID);
      end
      write_active = 1'b0;
      for (int j = 0; j < NS; j++) busy[j] = 1'b0;
      @(negedge clk);
      resetN = 1'b1;
      repeat (4) @(negedge clk);
      n_checks++;
      if (write_source_sel !== IDLE_ID || fb_we !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_recover: got sel=%0d we=%b, required sel=%0d we=0", write_source_sel, fb_we, IDLE_ID);
      end
   endtask

   initial begin
      test_reset();
      test_basic_pass();
      test_pixel_boundaries();
      test_overrun();
      test_swap_frame();
      test_max_stream();
      test_random();
      test_reset_mid();
      tname = "after_reset";
      new_setup();
      add_src(0, 12, 1'b0);
      add_src(1, 9, 1'b0);
      run_pass(0, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
